// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches instructions over a req/ack memory port into a one-entry decode register with PC stall, HLT stop and redirect flush
module instr_fetch_unit #(
  parameter int ADDR_W = 16,
  parameter int INSTR_W = 16,
  parameter logic [3:0] HLT_OP = 4'hF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_addr,
  output logic               pc_stall,
  input  logic               redirect,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               inst_valid,
  output logic [INSTR_W-1:0] inst,
  output logic [ADDR_W-1:0]  inst_pc,
  input  logic               dec_ready,
  output logic               halt_seen
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD, HALTED} state_t;
  state_t state, stateNext;
  logic [ADDR_W-1:0] reqAddr, holdPc, instPc, loadPc;
  logic [INSTR_W-1:0] holdInst, instR, loadInst;
  logic drop, dropNext, validR, load, toHold, isHlt;
  assign mem_req = state == REQ;
  assign mem_addr = reqAddr;
  assign inst_valid = validR;
  assign inst = instR;
  assign inst_pc = instPc;
  assign halt_seen = state == HALTED;
  always_comb begin
    stateNext = state;
    dropNext = drop;
    load = 1'b0;
    toHold = 1'b0;
    loadInst = state == HOLD ? holdInst : mem_rdata;
    loadPc = state == HOLD ? holdPc : reqAddr;
    case (state)
      IDLE: stateNext = redirect ? IDLE : REQ;
      REQ: begin
        if (mem_ack) begin
          dropNext = 1'b0;
          stateNext = IDLE;
          if (!redirect && !drop) begin
            load = !validR || dec_ready;
            toHold = !load;
            stateNext = load ? IDLE : HOLD;
          end
        end else if (redirect) begin
          dropNext = 1'b1;
        end
      end
      HOLD: begin
        load = !redirect && dec_ready;
        stateNext = (redirect || dec_ready) ? IDLE : HOLD;
      end
      default: stateNext = HALTED;
    endcase
    isHlt = loadInst[INSTR_W-1 -: 4] == HLT_OP;
    if (load && isHlt) stateNext = HALTED;
    // an HLT transfer keeps the PC parked on the HLT itself
    pc_stall = !((load && !isHlt) || (redirect && state != HALTED));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      reqAddr <= '0;
      drop <= 1'b0;
      holdInst <= '0;
      holdPc <= '0;
      instR <= '0;
      instPc <= '0;
      validR <= 1'b0;
    end else begin
      state <= stateNext;
      drop <= dropNext;
      if (state == IDLE) reqAddr <= pc_addr;
      if (toHold) begin
        holdInst <= mem_rdata;
        holdPc <= reqAddr;
      end
      if (load) begin
        instR <= loadInst;
        instPc <= loadPc;
      end
      validR <= redirect ? 1'b0 : load ? 1'b1 : (validR && dec_ready) ? 1'b0 : validR;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed vector table plus hand sequences for latency, halt and reset corners
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic rst, redirect, mem_ack, dec_ready;
  logic [15:0] pc_addr, mem_rdata;
  logic pc_stall, mem_req, inst_valid, halt_seen;
  logic [15:0] mem_addr, inst, inst_pc;
  int nPass = 0;
  int nTotal = 0;
  always #5 clk = ~clk;
  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .pc_addr(pc_addr), .pc_stall(pc_stall), .redirect(redirect),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .dec_ready(dec_ready),
    .halt_seen(halt_seen)
  );
  typedef struct {
    logic rst, redir, ack, dec;
    logic [15:0] pc, rdata;
    logic stall, req;
    logic [15:0] addr;
    logic iv;
    logic [15:0] ins, ipc;
    logic halt;
  } vec_t;
  vec_t vecs[22];
  task automatic drive(input logic r, input logic rd, input logic a, input logic d,
                       input logic [15:0] pc, input logic [15:0] data);
    @(negedge clk);
    rst = r;
    redirect = rd;
    mem_ack = a;
    dec_ready = d;
    pc_addr = pc;
    mem_rdata = data;
    #1;
  endtask
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    nTotal++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  task automatic chkReset(input string nm);
    chk({nm, " stall"}, 16'(pc_stall), 16'd1);
    chk({nm, " req"}, 16'(mem_req), 16'd0);
    chk({nm, " addr"}, mem_addr, 16'h0);
    chk({nm, " iv"}, 16'(inst_valid), 16'd0);
    chk({nm, " inst"}, inst, 16'h0);
    chk({nm, " ipc"}, inst_pc, 16'h0);
    chk({nm, " halt"}, 16'(halt_seen), 16'd0);
  endtask
  initial begin
    vecs[0]  = '{0,0,0,1,16'h0000,16'h0000, 1,0,16'h0000,0,16'h0000,16'h0000,0};
    vecs[1]  = '{0,0,1,1,16'h0000,16'h1234, 0,1,16'h0000,0,16'h0000,16'h0000,0};
    vecs[2]  = '{0,0,0,0,16'h0002,16'h0000, 1,0,16'h0000,1,16'h1234,16'h0000,0};
    vecs[3]  = '{0,0,1,1,16'h0002,16'hA001, 0,1,16'h0002,1,16'h1234,16'h0000,0};
    vecs[4]  = '{0,0,0,0,16'h0004,16'h0000, 1,0,16'h0002,1,16'hA001,16'h0002,0};
    vecs[5]  = '{0,0,1,0,16'h0004,16'hA002, 1,1,16'h0004,1,16'hA001,16'h0002,0};
    vecs[6]  = '{0,0,0,0,16'h0004,16'h0000, 1,0,16'h0004,1,16'hA001,16'h0002,0};
    vecs[7]  = '{0,0,0,1,16'h0004,16'h0000, 0,0,16'h0004,1,16'hA001,16'h0002,0};
    vecs[8]  = '{0,0,0,1,16'h0006,16'h0000, 1,0,16'h0004,1,16'hA002,16'h0004,0};
    vecs[9]  = '{0,1,0,1,16'h0040,16'h0000, 0,1,16'h0006,0,16'hA002,16'h0004,0};
    vecs[10] = '{0,0,0,1,16'h0040,16'h0000, 1,1,16'h0006,0,16'hA002,16'h0004,0};
    vecs[11] = '{0,0,0,1,16'h0040,16'h0000, 1,1,16'h0006,0,16'hA002,16'h0004,0};
    vecs[12] = '{0,0,1,1,16'h0040,16'hBAD1, 1,1,16'h0006,0,16'hA002,16'h0004,0};
    vecs[13] = '{0,0,0,1,16'h0040,16'h0000, 1,0,16'h0006,0,16'hA002,16'h0004,0};
    vecs[14] = '{0,0,1,1,16'h0040,16'h5555, 0,1,16'h0040,0,16'hA002,16'h0004,0};
    vecs[15] = '{0,0,0,0,16'h0042,16'h0000, 1,0,16'h0040,1,16'h5555,16'h0040,0};
    vecs[16] = '{0,1,1,0,16'h0042,16'h6666, 0,1,16'h0042,1,16'h5555,16'h0040,0};
    vecs[17] = '{0,0,0,1,16'h0010,16'h0000, 1,0,16'h0042,0,16'h5555,16'h0040,0};
    vecs[18] = '{0,0,1,1,16'h0010,16'hF000, 1,1,16'h0010,0,16'h5555,16'h0040,0};
    vecs[19] = '{0,0,1,0,16'h0012,16'h1111, 1,0,16'h0010,1,16'hF000,16'h0010,1};
    vecs[20] = '{0,0,0,1,16'h0012,16'h0000, 1,0,16'h0010,1,16'hF000,16'h0010,1};
    vecs[21] = '{0,1,0,1,16'h0012,16'h0000, 1,0,16'h0010,0,16'hF000,16'h0010,1};
    rst = 1'b1;
    redirect = 1'b0;
    mem_ack = 1'b0;
    dec_ready = 1'b0;
    pc_addr = '0;
    mem_rdata = '0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].rst, vecs[i].redir, vecs[i].ack, vecs[i].dec, vecs[i].pc, vecs[i].rdata);
      chk($sformatf("r%0d stall", i), 16'(pc_stall), 16'(vecs[i].stall));
      chk($sformatf("r%0d req", i), 16'(mem_req), 16'(vecs[i].req));
      chk($sformatf("r%0d addr", i), mem_addr, vecs[i].addr);
      chk($sformatf("r%0d iv", i), 16'(inst_valid), 16'(vecs[i].iv));
      chk($sformatf("r%0d inst", i), inst, vecs[i].ins);
      chk($sformatf("r%0d ipc", i), inst_pc, vecs[i].ipc);
      chk($sformatf("r%0d halt", i), 16'(halt_seen), 16'(vecs[i].halt));
    end
    for (int k = 0; k < 20; k++) begin
      drive(0, 1'(k % 3 == 0), 1'(k & 1), 1, 16'($urandom), 16'($urandom));
      chk($sformatf("halted%0d req", k), 16'(mem_req), 16'd0);
      chk($sformatf("halted%0d stall", k), 16'(pc_stall), 16'd1);
      chk($sformatf("halted%0d halt", k), 16'(halt_seen), 16'd1);
    end
    drive(1, 0, 0, 1, 16'h0100, 16'h0);
    drive(0, 0, 0, 1, 16'h0100, 16'h0);
    chkReset("after halt rst");
    for (int k = 0; k < 3; k++) begin
      for (int j = 1; j <= 4; j++) begin
        drive(0, 0, 1'(j == 4), 1, 16'h0100 + 16'(k + 1), 16'hC000 + 16'(k));
        chk($sformatf("lat%0d.%0d req", k, j), 16'(mem_req), 16'd1);
        chk($sformatf("lat%0d.%0d addr", k, j), mem_addr, 16'h0100 + 16'(k));
        chk($sformatf("lat%0d.%0d stall", k, j), 16'(pc_stall), 16'(j != 4));
      end
      drive(0, 0, 0, 1, 16'h0100 + 16'(k + 1), 16'h0);
      chk($sformatf("lat%0d idle req", k), 16'(mem_req), 16'd0);
      chk($sformatf("lat%0d idle stall", k), 16'(pc_stall), 16'd1);
      chk($sformatf("lat%0d iv", k), 16'(inst_valid), 16'd1);
      chk($sformatf("lat%0d inst", k), inst, 16'hC000 + 16'(k));
      chk($sformatf("lat%0d ipc", k), inst_pc, 16'h0100 + 16'(k));
    end
    drive(1, 0, 0, 0, 16'h0300, 16'h0);
    chk("rst req pre", 16'(mem_req), 16'd1);
    chk("rst req addr", mem_addr, 16'h0103);
    drive(0, 0, 0, 0, 16'h0300, 16'h0);
    chkReset("rst in req");
    drive(0, 0, 1, 0, 16'h0300, 16'h7001);
    chk("fill stall", 16'(pc_stall), 16'd0);
    chk("fill addr", mem_addr, 16'h0300);
    drive(0, 0, 0, 0, 16'h0302, 16'h0);
    chk("fill inst", inst, 16'h7001);
    chk("fill ipc", inst_pc, 16'h0300);
    drive(0, 0, 1, 0, 16'h0302, 16'h7002);
    chk("to hold stall", 16'(pc_stall), 16'd1);
    drive(1, 0, 0, 0, 16'h0302, 16'h0);
    chk("hold req", 16'(mem_req), 16'd0);
    chk("hold stall", 16'(pc_stall), 16'd1);
    chk("hold inst", inst, 16'h7001);
    drive(0, 0, 0, 1, 16'h0400, 16'h0);
    chkReset("rst in hold");
    drive(0, 0, 0, 1, 16'h0400, 16'h0);
    chk("post hold iv", 16'(inst_valid), 16'd0);
    chk("post hold addr", mem_addr, 16'h0400);
    chk("post hold req", 16'(mem_req), 16'd1);
    drive(0, 0, 1, 1, 16'h0400, 16'h8888);
    chk("post hold stall", 16'(pc_stall), 16'd0);
    drive(0, 0, 0, 1, 16'h0402, 16'h0);
    chk("post hold iv2", 16'(inst_valid), 16'd1);
    chk("post hold inst", inst, 16'h8888);
    chk("post hold ipc", inst_pc, 16'h0400);
    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end
endmodule
